// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with a valid/ready handshake on both sides.
// Most opcodes finish one cycle after they are accepted. The optional
// multiply takes WIDTH extra cycles and is built only when the macro
// ALU_PIPE_MUL_EN is defined. Without the macro, opcode 1101 is reported
// as an illegal opcode.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst_n      synchronous reset, active low
//   in_valid   an operand/opcode bundle is presented
//   in_ready   the block accepts the bundle in this cycle
//   operand1   first operand (WIDTH bits)
//   operand2   second operand, or the shift amount in its low SHW bits
//   opcode     operation select (4 bits)
//   out_valid  result, zero_flag and illegal_op are valid
//   out_ready  the consumer takes the result in this cycle
//   result     registered result (WIDTH bits)
//   zero_flag  high when result == 0
//   illegal_op high when the opcode is not supported
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             illegal_op
);

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  localparam int CW = $clog2(WIDTH);
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t           state;
  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic [SHW-1:0]   sh;

  assign out_valid = (state == DONE);
  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  // Only the low bits of operand2 set the shift amount.
  assign sh        = operand2[SHW-1:0];

  // Single-cycle datapath. An illegal opcode produces 0, so zero_flag is 1.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (opcode)
      4'h0: alu_res = operand1 + operand2;
      4'h1: alu_res = operand1 - operand2;
      4'h2: alu_res = operand1 & operand2;
      4'h3: alu_res = operand1 | operand2;
      4'h4: alu_res = operand1 ^ operand2;
      4'h5: alu_res = ~operand1;
      4'h6: alu_res = operand1 << sh;
      4'h7: alu_res = operand1 >> sh;
      4'h8: alu_res = operand1 + 1'b1;
      4'h9: alu_res = operand1 - 1'b1;
      4'hA: alu_res = $signed(operand1) >>> sh;
      4'hB: alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
      4'hC: alu_res = {{(WIDTH-1){1'b0}}, (operand1 < operand2)};
`ifdef ALU_PIPE_MUL_EN
      4'hD: alu_res = '0;  // produced by the iterative multiplier
`endif
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  // Shift-add multiplier. Each BUSY cycle retires one multiplier bit, LSB first.
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_next;

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      result     <= '0;
      zero_flag  <= 1'b0;
      illegal_op <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      count      <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
`ifdef ALU_PIPE_MUL_EN
            if (opcode == 4'hD) begin
              state  <= BUSY;
              mcand  <= operand1;
              mplier <= operand2;
              acc    <= '0;
              count  <= '0;
            end else
`endif
            begin
              state      <= DONE;
              result     <= alu_res;
              zero_flag  <= (alu_res == '0);
              illegal_op <= alu_ill;
            end
          end else if (state == DONE && out_ready) begin
            state <= IDLE;
          end
        end
`ifdef ALU_PIPE_MUL_EN
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          // The last iteration writes the result directly, so out_valid
          // rises WIDTH+1 cycles after the accept.
          if (count == CW'(WIDTH - 1)) begin
            state      <= DONE;
            result     <= acc_next;
            zero_flag  <= (acc_next == '0);
            illegal_op <= 1'b0;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), number of operand2 low bits used as shift amount.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand/opcode bundle presented.
REQ-006 in_ready  output  1  block accepts bundle this cycle.
REQ-007 operand1  input  WIDTH  first operand.
REQ-008 operand2  input  WIDTH  second operand / shift amount.
REQ-009 opcode  input  4  operation select, encoding per REQ-014.
REQ-010 out_valid  output  1  result, zero_flag, illegal_op valid.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 result  output  WIDTH  registered result.
REQ-013 zero_flag  output  1  1 when result == 0; illegal_op  output  1  1 when opcode unsupported.

Function
REQ-014 Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT operand1, 0110 SLL, 0111 SRL, 1000 INC operand1, 1001 DEC operand1, 1010 SRA, 1011 SLT signed, 1100 SLTU unsigned, 1101 MUL; 1110/1111 illegal.
REQ-015 All arithmetic modulo 2^WIDTH; no carry/overflow output; SLT/SLTU result is 0 or 1 zero-extended.
REQ-016 Shifts use operand2[SHW-1:0] only; upper operand2 bits ignored; SRA replicates operand1[WIDTH-1].
REQ-017 MUL returns low WIDTH bits of unsigned product, computed by iterative shift-add, one multiplier bit per cycle.
REQ-018 FSM states IDLE, BUSY, DONE; IDLE->DONE on accept of non-MUL op; IDLE->BUSY on accept of MUL; BUSY->DONE after WIDTH iterations; DONE->IDLE on out_ready without new accept; DONE->DONE/BUSY on out_ready with simultaneous accept.
REQ-019 Accept = in_valid & in_ready; in_ready = (state==IDLE) | (state==DONE & out_ready); inputs captured only on accept.
REQ-020 Latency: accept in cycle N; non-MUL out_valid in cycle N+1; MUL out_valid in cycle N+WIDTH+1.
REQ-021 out_valid = (state==DONE); result, zero_flag, illegal_op held stable while out_valid & ~out_ready.
REQ-022 Illegal opcode: completes with 1-cycle latency, result 0, zero_flag 1, illegal_op 1.
REQ-023 Back-to-back: result drained and new bundle accepted in same cycle, no bubble for non-MUL ops (one result per cycle).
REQ-024 in_valid while in_ready low: bundle ignored, no state change; producer holds it.

Reset
REQ-025 rst_n low at a rising edge: state IDLE, out_valid 0, result 0, zero_flag 0, illegal_op 0, MUL accumulator/counter 0.
REQ-026 Reset mid-MUL or in DONE discards the operation; no out_valid follows; in_ready 1 in the first cycle after reset release.

Configuration
REQ-027 Macro ALU_PIPE_MUL_EN defined: MUL datapath, counter and BUSY state compiled in, per REQ-017/018/020.
REQ-028 ALU_PIPE_MUL_EN undefined: no multiplier logic or BUSY state; opcode 1101 treated as illegal per REQ-022.

Verification (WIDTH=32)
REQ-029 ADD 0xFFFFFFFF + 0x00000001, out_ready 1 -> out_valid cycle N+1, result 0, zero_flag 1, illegal_op 0.
REQ-030 SRA 0x80000000 by operand2 0x00000024 -> result 0xF8000000 (shift 4); SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0.
REQ-031 MUL 7 x 6 -> result 42 at cycle N+33, in_ready 0 during BUSY; MUL 0x00010000 x 0x00010000 -> result 0, zero_flag 1.
REQ-032 Backpressure: out_ready low 3 cycles after XOR 0xF0F0F0F0,0xFF00FF00 -> result 0x0FF00FF0 held, in_ready 0; then streamed ADDs with out_ready 1 -> one result per cycle.
REQ-033 rst_n low 1 cycle at cycle N+10 of a MUL -> out_valid never asserts for it, outputs 0, next ADD 2+3 returns 5 at one-cycle latency.
REQ-034 ALU_PIPE_MUL_EN undefined, opcode 1101 or 1111 -> result 0, zero_flag 1, illegal_op 1 at cycle N+1.
